// File: rtl/mcu_resp_pkg.sv
// Shared types and constants for the MCU GPIO link responder.
package mcu_resp_pkg;

  localparam int unsigned CMD_W = 8;
  localparam logic [CMD_W-1:0] CMD_WRITE = 8'h01;
  localparam logic [CMD_W-1:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StRdata,
    StIgnore
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mcu_resp_sync.sv
// Multi-flop synchroniser for one MCU input line with rise/fall detection on the synced value.
module mcu_resp_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] chain_q;
  logic                  prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SyncStages-2:0], din_i};
      prev_q  <= chain_q[SyncStages-1];
    end
  end

  assign sync_o = chain_q[SyncStages-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/mcu_gpio_responder.sv
// Fabric-side responder decoding framed MCU bit-bang transfers into local memory accesses.
// Define MCU_RESP_BURST_EN for multi-word frames with auto-incrementing address.
module mcu_gpio_responder
  import mcu_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              ppm_clk,
  input  logic              rst_n,
  input  logic              mcu_cs_n,
  input  logic              mcu_sclk,
  input  logic              mcu_mosi,
  output logic              mcu_miso,
  output logic              mcu_miso_oe_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_err
);

  localparam int unsigned CntW = $clog2(max3(CMD_W, ADDR_W, DATA_W)) + 1;

  logic cs_rise, cs_fall, cs_sync_unused;
  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  mcu_resp_sync #(.SyncStages(SYNC_STAGES)) u_sync_cs (
    .clk(ppm_clk), .rst_n(rst_n), .din_i(mcu_cs_n),
    .sync_o(cs_sync_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  mcu_resp_sync #(.SyncStages(SYNC_STAGES)) u_sync_sclk (
    .clk(ppm_clk), .rst_n(rst_n), .din_i(mcu_sclk),
    .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  mcu_resp_sync #(.SyncStages(SYNC_STAGES)) u_sync_mosi (
    .clk(ppm_clk), .rst_n(rst_n), .din_i(mcu_mosi),
    .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, tx_q;
  logic              we_q, re_q, rd_wait_q, err_q, oe_n_q;
`ifdef MCU_RESP_BURST_EN
  logic [DATA_W-1:0] nxt_q;
  logic              first_q;
`endif

  logic [CMD_W-1:0]  cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  assign cmd_nxt   = {cmd_q[CMD_W-2:0], mosi_s};
  assign addr_nxt  = {addr_q[ADDR_W-2:0], mosi_s};
  assign wdata_nxt = {wdata_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge ppm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_q      <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_wait_q <= 1'b0;
      err_q     <= 1'b0;
      oe_n_q    <= 1'b1;
`ifdef MCU_RESP_BURST_EN
      nxt_q     <= '0;
      first_q   <= 1'b0;
`endif
    end else begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_wait_q <= re_q;
`ifdef MCU_RESP_BURST_EN
      // Only the first word of a read loads tx directly; later words wait in nxt_q.
      if (rd_wait_q) begin
        if (first_q) tx_q <= mem_rdata;
        else         nxt_q <= mem_rdata;
      end
      if (we_q) addr_q <= addr_q + 1'b1;
`else
      if (rd_wait_q) tx_q <= mem_rdata;
`endif
      if (cs_rise && state_q != StIdle) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        oe_n_q  <= 1'b1;
`ifdef MCU_RESP_BURST_EN
        err_q   <= state_q inside {StCmd, StAddr};
`else
        err_q   <= state_q inside {StCmd, StAddr, StWdata, StRdata};
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q <= StCmd;
              cnt_q   <= '0;
            end
          end
          StCmd: begin
            if (sclk_rise) begin
              cmd_q <= cmd_nxt;
              if (cnt_q == CntW'(CMD_W - 1)) begin
                cnt_q <= '0;
                if (cmd_nxt inside {CMD_WRITE, CMD_READ}) begin
                  state_q <= StAddr;
                end else begin
                  state_q <= StIgnore;
                  err_q   <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StAddr: begin
            if (sclk_rise) begin
              addr_q <= addr_nxt;
              if (cnt_q == CntW'(ADDR_W - 1)) begin
                cnt_q <= '0;
                if (cmd_q == CMD_READ) begin
                  state_q <= StRdata;
                  oe_n_q  <= 1'b0;
                  re_q    <= 1'b1;
`ifdef MCU_RESP_BURST_EN
                  first_q <= 1'b1;
`endif
                end else begin
                  state_q <= StWdata;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StWdata: begin
            if (sclk_rise) begin
              wdata_q <= wdata_nxt;
              if (cnt_q == CntW'(DATA_W - 1)) begin
                cnt_q <= '0;
                we_q  <= 1'b1;
`ifndef MCU_RESP_BURST_EN
                state_q <= StIgnore;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StRdata: begin
            // The fall right after the last address bit must not shift: bit MSB is still unread.
            if (sclk_fall) begin
              if (cnt_q != '0) tx_q <= tx_q << 1;
`ifdef MCU_RESP_BURST_EN
              else if (!first_q) tx_q <= nxt_q;
              if (cnt_q == CntW'(DATA_W - 1)) begin
                re_q   <= 1'b1;
                addr_q <= addr_q + 1'b1;
              end
`endif
            end
            if (sclk_rise) begin
`ifdef MCU_RESP_BURST_EN
              first_q <= 1'b0;
`endif
              if (cnt_q == CntW'(DATA_W - 1)) begin
                cnt_q <= '0;
`ifndef MCU_RESP_BURST_EN
                state_q <= StIgnore;
                oe_n_q  <= 1'b1;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StIgnore: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_we        = we_q;
  assign mem_re        = re_q;
  assign frame_err     = err_q;
  assign mcu_miso_oe_n = oe_n_q;
  assign mcu_miso      = tx_q[DATA_W-1] & ~oe_n_q;

endmodule
